// File: rtl/nf10_axis_tx_downsizer.sv
// nf10_axis_tx_downsizer
// AXI4-Stream width converter. It accepts wide packet beats from a BRAM output
// queue and re-emits them as narrow beats toward the TX/MAC interface.
// Trailing all-zero lanes of the last wide beat of a packet are not emitted.
// Optional feature macro: DOWNSIZER_STATS_EN adds the 32-bit pkt_count output.
module nf10_axis_tx_downsizer #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_DATA_WIDTH  = 64,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast
`ifdef DOWNSIZER_STATS_EN
  ,
  output logic [31:0]                       pkt_count
`endif
);

  localparam int RATIO  = C_S_AXIS_DATA_WIDTH / C_M_AXIS_DATA_WIDTH;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int SB     = C_S_AXIS_DATA_WIDTH / 8;
  localparam int MB     = C_M_AXIS_DATA_WIDTH / 8;

  typedef enum logic {EMPTY, SEND} state_t;

  state_t                            state_q, state_d;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    data_q, data_d;
  logic [SB-1:0]                     strb_q, strb_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   user_q, user_d;
  logic                              last_q, last_d;
  logic [LANE_W-1:0]                 lane_q, lane_d;

  logic [LANE_W-1:0]                 finalLane;
  logic                              full;
  logic                              atFinal;
  logic                              inHs;
  logic                              outHs;

  // Last lane to emit: all lanes mid-packet, otherwise the highest lane with any strobe set
  always_comb begin
    finalLane = LANE_W'(RATIO - 1);
    if (last_q) begin
      finalLane = '0;
      for (int i = 0; i < RATIO; i++) begin
        if (|strb_q[i*MB +: MB]) finalLane = LANE_W'(i);
      end
    end
  end

  assign full    = (state_q == SEND);
  assign atFinal = (lane_q == finalLane);

  // Ready is forced low while reset is held; otherwise a new wide beat is taken when
  // the register is empty or its final lane is leaving this very cycle
  assign s_axis_tready = axi_resetn & (~full | (m_axis_tready & atFinal));
  assign inHs          = s_axis_tvalid & s_axis_tready;
  assign outHs         = full & m_axis_tready;

  // Next-state logic: load on input handshake, step lanes on output handshake
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    strb_d  = strb_q;
    user_d  = user_q;
    last_d  = last_q;
    lane_d  = lane_q;
    if (inHs) begin
      state_d = SEND;
      data_d  = s_axis_tdata;
      strb_d  = s_axis_tstrb;
      user_d  = s_axis_tuser;
      last_d  = s_axis_tlast;
      lane_d  = '0;
    end else if (outHs) begin
      if (atFinal) begin
        state_d = EMPTY;
      end else begin
        lane_d = lane_q + LANE_W'(1);
      end
    end
  end

  // Holding register and state, cleared asynchronously so a reset drops any held beat
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= EMPTY;
      data_q  <= '0;
      strb_q  <= '0;
      user_q  <= '0;
      last_q  <= 1'b0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      user_q  <= user_d;
      last_q  <= last_d;
      lane_q  <= lane_d;
    end
  end

  // Output lane select from the held wide beat
  always_comb begin
    m_axis_tdata = '0;
    m_axis_tstrb = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (lane_q == LANE_W'(i)) begin
        m_axis_tdata = data_q[i*C_M_AXIS_DATA_WIDTH +: C_M_AXIS_DATA_WIDTH];
        m_axis_tstrb = strb_q[i*MB +: MB];
      end
    end
  end

  assign m_axis_tuser  = user_q;
  assign m_axis_tvalid = full;
  assign m_axis_tlast  = full & last_q & atFinal;

`ifdef DOWNSIZER_STATS_EN
  logic [31:0] pkt_count_q;

  // Packet counter: one count per emitted tlast beat, wrapping naturally
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      pkt_count_q <= '0;
    end else if (outHs && m_axis_tlast) begin
      pkt_count_q <= pkt_count_q + 32'd1;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_nf10_axis_tx_downsizer.sv
// Scoreboard bench for nf10_axis_tx_downsizer: the driver pushes expected narrow
// beats as wide beats are accepted, a negedge monitor pops and compares them.
module tb_nf10_axis_tx_downsizer;

  localparam int S = 256;
  localparam int M = 64;
  localparam int U = 128;

  typedef struct packed {
    logic [63:0]  data;
    logic [7:0]   strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic [S-1:0]   s_tdata = '0;
  logic [S/8-1:0] s_tstrb = '0;
  logic [U-1:0]   s_tuser = '0;
  logic           s_tvalid = 1'b0;
  logic           s_tready;
  logic           s_tlast = 1'b0;
  logic [M-1:0]   m_tdata;
  logic [M/8-1:0] m_tstrb;
  logic [U-1:0]   m_tuser;
  logic           m_tvalid;
  logic           m_tready = 1'b1;
  logic           m_tlast;
`ifdef DOWNSIZER_STATS_EN
  logic [31:0]    pkt_count;
`endif

  beat_t       expQ[$];
  longint      hsCyc[$];
  longint      cyc = 0;
  int          checks = 0;
  int          fails = 0;
  int          beatCount = 0;
  logic [7:0]  lastStrb = '0;
  logic        lastLast = 1'b0;
  logic        randReady = 1'b0;

  nf10_axis_tx_downsizer dut (
    .axi_aclk      (clk),
    .axi_resetn    (rstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tstrb  (s_tstrb),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tstrb  (m_tstrb),
    .m_axis_tuser  (m_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast)
`ifdef DOWNSIZER_STATS_EN
    ,
    .pkt_count     (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model of lane emission for one accepted wide beat
  task automatic pushExpected(input logic [S-1:0] d, input logic [31:0] s, input logic [U-1:0] u, input logic l);
    int fl;
    beat_t b;
    fl = 3;
    if (l) begin
      fl = 0;
      for (int i = 0; i < 4; i++) if (s[i*8 +: 8] != 8'h00) fl = i;
    end
    for (int i = 0; i <= fl; i++) begin
      b.data = d[i*64 +: 64];
      b.strb = s[i*8 +: 8];
      b.user = u;
      b.last = l && (i == fl);
      expQ.push_back(b);
    end
  endtask

  task automatic applyStimulus(input logic [S-1:0] d, input logic [31:0] s, input logic [U-1:0] u, input logic l);
    int t = 0;
    s_tdata  = d;
    s_tstrb  = s;
    s_tuser  = u;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!s_tready) begin
      checks++;
      fails++;
      $display("[TB] FAIL input_accept_timeout: got ready=0 required ready=1");
    end else begin
      pushExpected(d, s, u, l);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleInput();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic waitDrain();
    int t = 0;
    while ((expQ.size() != 0 || m_tvalid) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("drain_queue_empty", 128'(expQ.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  // Random backpressure source
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) m_tready = 1'($urandom % 2);
    end
  end

  // Monitor: scoreboard compare on each handshake, plus stability under backpressure
  initial begin
    logic        prevHold;
    logic [63:0] prevData;
    beat_t       e;
    prevHold = 1'b0;
    prevData = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prevHold = 1'b0;
      end else begin
        if (prevHold) begin
          checkOutput("hold_valid", 128'(m_tvalid), 128'd1);
          checkOutput("hold_data", 128'(m_tdata), 128'(prevData));
        end
        if (m_tvalid && m_tready) begin
          if (expQ.size() == 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL unexpected_beat: got data %0h expected no beat", m_tdata);
          end else begin
            e = expQ.pop_front();
            checkOutput("beat_data", 128'(m_tdata), 128'(e.data));
            checkOutput("beat_strb", 128'(m_tstrb), 128'(e.strb));
            checkOutput("beat_user", m_tuser, e.user);
            checkOutput("beat_last", 128'(m_tlast), 128'(e.last));
          end
          beatCount++;
          lastStrb = m_tstrb;
          lastLast = m_tlast;
          hsCyc.push_back(cyc);
        end
        prevHold = m_tvalid && !m_tready;
        prevData = m_tdata;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [S-1:0]   d;
    logic [U-1:0]   u;
    logic [31:0]    s;
    int             base;
    int             len;
    int             nb;
    int             rem;

    // Reset state
    #12;
    checkOutput("reset_tvalid", 128'(m_tvalid), 128'd0);
    checkOutput("reset_tready_s", 128'(s_tready), 128'd0);
    checkOutput("reset_tdata", 128'(m_tdata), 128'd0);
    checkOutput("reset_tlast", 128'(m_tlast), 128'd0);
    checkOutput("reset_tuser", m_tuser, 128'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    checkOutput("post_reset_tready_s", 128'(s_tready), 128'd1);

    // 64-byte packet: two full wide beats, eight consecutive narrow beats
    $display("[TB] test 64-byte packet");
    base = beatCount;
    applyStimulus({64'h1111_1111_1111_1104, 64'h1111_1111_1111_1103, 64'h1111_1111_1111_1102, 64'h1111_1111_1111_1101},
                  32'hFFFF_FFFF, 128'hA5A5, 1'b0);
    applyStimulus({64'h2222_2222_2222_2204, 64'h2222_2222_2222_2203, 64'h2222_2222_2222_2202, 64'h2222_2222_2222_2201},
                  32'hFFFF_FFFF, 128'hA5A5, 1'b1);
    idleInput();
    waitDrain();
    checkOutput("p64_beat_count", 128'(beatCount - base), 128'd8);
    checkOutput("p64_last_strb", 128'(lastStrb), 128'hFF);
    checkOutput("p64_consecutive", 128'(hsCyc[hsCyc.size()-1] - hsCyc[hsCyc.size()-8]), 128'd7);

    // 60-byte packet: last lane carries four bytes
    $display("[TB] test 60-byte packet");
    base = beatCount;
    applyStimulus({4{64'h3333_0000_3333_0001}}, 32'hFFFF_FFFF, 128'h60, 1'b0);
    applyStimulus({64'h4444_0000_4444_0004, 64'h4444_0000_4444_0003, 64'h4444_0000_4444_0002, 64'h4444_0000_4444_0001},
                  32'h0FFF_FFFF, 128'h60, 1'b1);
    idleInput();
    waitDrain();
    checkOutput("p60_beat_count", 128'(beatCount - base), 128'd8);
    checkOutput("p60_last_strb", 128'(lastStrb), 128'h0F);
    checkOutput("p60_last_flag", 128'(lastLast), 128'd1);

    // Last wide beat with only lane 0 valid
    $display("[TB] test single-lane last beat");
    base = beatCount;
    applyStimulus({64'hDEAD, 64'hBEEF, 64'hCAFE, 64'h0123_4567_89AB_CDEF}, 32'h0000_00FF, 128'h77, 1'b1);
    idleInput();
    waitDrain();
    checkOutput("lane0_beat_count", 128'(beatCount - base), 128'd1);
    checkOutput("lane0_last_strb", 128'(lastStrb), 128'hFF);

    // Last wide beat with no strobes at all
    $display("[TB] test all-zero strobe last beat");
    base = beatCount;
    applyStimulus({4{64'h5555_5555_5555_5555}}, 32'h0000_0000, 128'h88, 1'b1);
    idleInput();
    waitDrain();
    checkOutput("zstrb_beat_count", 128'(beatCount - base), 128'd1);
    checkOutput("zstrb_last_strb", 128'(lastStrb), 128'h00);
    checkOutput("zstrb_last_flag", 128'(lastLast), 128'd1);

    // Reset while lane 2 is presented
    $display("[TB] test reset mid-beat");
    m_tready = 1'b0;
    base = beatCount;
    applyStimulus({64'h6666_0003, 64'h6666_0002, 64'h6666_0001, 64'h6666_0000}, 32'hFFFF_FFFF, 128'h99, 1'b0);
    idleInput();
    m_tready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_lanes_before", 128'(beatCount - base), 128'd2);
    checkOutput("rst_lane2_data", 128'(m_tdata), 128'h6666_0002);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_tvalid_drop", 128'(m_tvalid), 128'd0);
    checkOutput("rst_tready_s", 128'(s_tready), 128'd0);
    expQ.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    m_tready = 1'b1;
    #1;
    checkOutput("rst_release_tready_s", 128'(s_tready), 128'd1);
    base = beatCount;
    applyStimulus({64'h7777_0003, 64'h7777_0002, 64'h7777_0001, 64'h7777_0000}, 32'hFFFF_FFFF, 128'hAA, 1'b1);
    idleInput();
    waitDrain();
    checkOutput("rst_after_beat_count", 128'(beatCount - base), 128'd4);

    // Random-length packets under random backpressure
    $display("[TB] test random packets");
    randReady = 1'b1;
    for (int p = 0; p < 100; p++) begin
      len = $urandom_range(60, 1518);
      nb  = (len + 31) / 32;
      u   = {$urandom, $urandom, $urandom, $urandom};
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
        s = 32'hFFFF_FFFF;
        if (b == nb - 1) begin
          rem = len - 32 * (nb - 1);
          if (rem < 32) s = (32'h1 << rem) - 32'h1;
        end
        applyStimulus(d, s, u, b == nb - 1);
      end
      idleInput();
      if ($urandom % 4 == 0) begin
        @(posedge clk);
        #1;
      end
    end
    waitDrain();
    randReady = 1'b0;
    @(posedge clk);
    #1;
    m_tready = 1'b1;

`ifdef DOWNSIZER_STATS_EN
    // Packet counter wrap
    $display("[TB] test packet counter wrap");
    force dut.pkt_count_q = 32'hFFFF_FFFE;
    #2;
    release dut.pkt_count_q;
    @(posedge clk);
    #1;
    for (int p = 0; p < 3; p++) begin
      applyStimulus({4{64'h0BAD_0000 + 64'(p)}}, 32'hFFFF_FFFF, 128'(p), 1'b1);
      idleInput();
      waitDrain();
      case (p)
        0: checkOutput("stats_count_0", 128'(pkt_count), 128'hFFFF_FFFF);
        1: checkOutput("stats_count_1", 128'(pkt_count), 128'h0);
        default: checkOutput("stats_count_2", 128'(pkt_count), 128'h1);
      endcase
    end
`endif

    checkOutput("final_queue_empty", 128'(expQ.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
